// File: rtl/pipeline_row_collector_if.sv
// Result/row bus between the 4-array pipeline, the row collector and the
// downstream row consumer. The collector sits on the slave modport; the
// producer/consumer side (or a bench) uses the master modport.
interface pipeline_row_collector_if #(
   parameter int TILE_SIZE = 4,
   parameter int ACC_WIDTH = 32,
   parameter int SUM_WIDTH = 48,
   parameter int IDX_WIDTH = 8
);
   logic                                             start;
   logic                                             valid_out;
   logic [TILE_SIZE-1:0][TILE_SIZE-1:0][ACC_WIDTH-1:0] result_in;
   logic                                             row_valid_o;
   logic                                             row_ready_i;
   logic [SUM_WIDTH-1:0]                             row_sum_o;
   logic [IDX_WIDTH-1:0]                             row_idx_o;
   logic                                             busy;
   logic                                             job_done;
   logic                                             overrun;

   modport master (
      output start, valid_out, result_in, row_ready_i,
      input  row_valid_o, row_sum_o, row_idx_o, busy, job_done, overrun
   );

   modport slave (
      input  start, valid_out, result_in, row_ready_i,
      output row_valid_o, row_sum_o, row_idx_o, busy, job_done, overrun
   );
endinterface

// File: rtl/pipeline_row_collector.sv
// pipeline_row_collector: reduces each result tile to per-row sums,
// accumulates them over STEPS_PER_BLOCK beats per row block and streams the
// finished rows downstream over valid/ready. One drain buffer holds the
// previous block while the next one accumulates.
// Optional feature: define ROW_COLLECT_SAT_EN to saturate accumulation to the
// signed SUM_WIDTH range (a saturation event also raises overrun); otherwise
// accumulation wraps modulo 2^SUM_WIDTH.
module pipeline_row_collector #(
   parameter int TILE_SIZE       = 4,
   parameter int ACC_WIDTH       = 32,
   parameter int SUM_WIDTH       = 48,
   parameter int STEPS_PER_BLOCK = 19,
   parameter int ROW_BLOCKS      = 10,
   parameter int IDX_WIDTH       = 8
) (
   input logic clk,
   input logic rst,
   pipeline_row_collector_if.slave bus
);
   localparam int BEAT_W = (STEPS_PER_BLOCK > 1) ? $clog2(STEPS_PER_BLOCK) : 1;
   localparam int BLK_W  = $clog2(ROW_BLOCKS + 1);
   localparam int PTR_W  = (TILE_SIZE > 1) ? $clog2(TILE_SIZE) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_LAST = 2'd2;

   logic [1:0]                  state;
   logic signed [SUM_WIDTH-1:0] acc      [TILE_SIZE];
   logic signed [SUM_WIDTH-1:0] next_sum [TILE_SIZE];
   logic signed [SUM_WIDTH-1:0] buf_sum  [TILE_SIZE];
   logic [IDX_WIDTH-1:0]        buf_base;
   logic                        buf_full;
   logic [PTR_W-1:0]            rd_ptr;
   logic [BEAT_W-1:0]           beat_cnt;
   logic [BLK_W-1:0]            blk_cnt;
   logic                        overrun_r;

   logic beat, blk_end, pop, pop_last, buf_free, done, start_acc;

   assign beat      = (state == S_RUN) && bus.valid_out;
   assign blk_end   = beat && (beat_cnt == BEAT_W'(STEPS_PER_BLOCK - 1));
   assign pop       = buf_full && bus.row_ready_i;
   assign pop_last  = pop && (rd_ptr == PTR_W'(TILE_SIZE - 1));
   // a block ending in the same cycle the last row leaves may take the buffer
   assign buf_free  = !buf_full || pop_last;
   assign done      = (state == S_LAST) && !buf_full;
   assign start_acc = bus.start && ((state == S_IDLE) || done);

`ifdef ROW_COLLECT_SAT_EN
   // wide enough that acc + rowsum cannot overflow before the clamp
   localparam int EXT_W = SUM_WIDTH + ACC_WIDTH + 1;
   localparam logic signed [EXT_W-1:0] SAT_MAX =
      {{(EXT_W-SUM_WIDTH+1){1'b0}}, {(SUM_WIDTH-1){1'b1}}};
   localparam logic signed [EXT_W-1:0] SAT_MIN =
      {{(EXT_W-SUM_WIDTH+1){1'b1}}, {(SUM_WIDTH-1){1'b0}}};
   logic [TILE_SIZE-1:0] sat_hit;

   // row reduction plus accumulate, clamped to the signed SUM_WIDTH range
   always_comb begin
      logic signed [EXT_W-1:0] ext;
      ext     = '0;
      sat_hit = '0;
      for (int i = 0; i < TILE_SIZE; i++) begin
         next_sum[i] = '0;
         ext = {{(EXT_W-SUM_WIDTH){acc[i][SUM_WIDTH-1]}}, acc[i]};
         for (int j = 0; j < TILE_SIZE; j++)
            ext = ext + {{(EXT_W-ACC_WIDTH){bus.result_in[i][j][ACC_WIDTH-1]}},
                         bus.result_in[i][j]};
         if (ext > SAT_MAX) begin
            next_sum[i] = SAT_MAX[SUM_WIDTH-1:0];
            sat_hit[i]  = 1'b1;
         end else if (ext < SAT_MIN) begin
            next_sum[i] = SAT_MIN[SUM_WIDTH-1:0];
            sat_hit[i]  = 1'b1;
         end else begin
            next_sum[i] = ext[SUM_WIDTH-1:0];
         end
      end
   end
`else
   // row reduction plus accumulate, wrapping modulo 2^SUM_WIDTH
   always_comb begin
      for (int i = 0; i < TILE_SIZE; i++) begin
         next_sum[i] = acc[i];
         for (int j = 0; j < TILE_SIZE; j++)
            next_sum[i] = next_sum[i] +
               {{(SUM_WIDTH-ACC_WIDTH){bus.result_in[i][j][ACC_WIDTH-1]}},
                bus.result_in[i][j]};
      end
   end
`endif

   // job sequencing: IDLE -> RUN -> LAST (drain) -> IDLE
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE: if (bus.start) state <= S_RUN;
            S_RUN:  if (blk_end && (blk_cnt == BLK_W'(ROW_BLOCKS - 1))) state <= S_LAST;
            S_LAST: if (!buf_full) state <= bus.start ? S_RUN : S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // row accumulators and beat/block counters
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < TILE_SIZE; i++) acc[i] <= '0;
         beat_cnt <= '0;
         blk_cnt  <= '0;
      end else if (start_acc) begin
         for (int i = 0; i < TILE_SIZE; i++) acc[i] <= '0;
         beat_cnt <= '0;
         blk_cnt  <= '0;
      end else if (beat) begin
         if (blk_end) begin
            for (int i = 0; i < TILE_SIZE; i++) acc[i] <= '0;
            beat_cnt <= '0;
            blk_cnt  <= blk_cnt + BLK_W'(1);
         end else begin
            for (int i = 0; i < TILE_SIZE; i++) acc[i] <= next_sum[i];
            beat_cnt <= beat_cnt + BEAT_W'(1);
         end
      end
   end

   // drain buffer: rows leave in order, a finished block loads when free
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < TILE_SIZE; i++) buf_sum[i] <= '0;
         buf_base <= '0;
         buf_full <= 1'b0;
         rd_ptr   <= '0;
      end else begin
         if (pop) begin
            if (pop_last) begin
               buf_full <= 1'b0;
               rd_ptr   <= '0;
            end else begin
               rd_ptr <= rd_ptr + PTR_W'(1);
            end
         end
         if (blk_end && buf_free) begin
            for (int i = 0; i < TILE_SIZE; i++) buf_sum[i] <= next_sum[i];
            buf_base <= IDX_WIDTH'(blk_cnt) * IDX_WIDTH'(TILE_SIZE);
            buf_full <= 1'b1;
            rd_ptr   <= '0;
         end
      end
   end

   // sticky overrun: a block finished with no room to park it
   always_ff @(posedge clk) begin
      if (rst) begin
         overrun_r <= 1'b0;
      end else if (start_acc) begin
         overrun_r <= 1'b0;
      end else begin
         if (blk_end && !buf_free) overrun_r <= 1'b1;
`ifdef ROW_COLLECT_SAT_EN
         if (beat && (|sat_hit)) overrun_r <= 1'b1;
`endif
      end
   end

   assign bus.row_valid_o = buf_full;
   assign bus.row_sum_o   = buf_sum[rd_ptr];
   assign bus.row_idx_o   = buf_base + IDX_WIDTH'(rd_ptr);
   assign bus.busy        = (state != S_IDLE) && !done;
   assign bus.job_done    = done;
   assign bus.overrun     = overrun_r;
endmodule
